// File: rtl/tpu_mem_pkg.sv
// Shared constants and types for the TPU data-memory access blocks.
//   DATA_ADDR_W      : word-address width of the 8192x32 data SRAM
//   DATA_W           : SRAM / stream data width
//   BURST_LEN_W      : burst length width (lengths 0..2^DATA_ADDR_W)
//   burst_rd_state_t : control states of the burst reader
package tpu_mem_pkg;

    localparam int DATA_ADDR_W = 13;
    localparam int DATA_W      = 32;
    localparam int BURST_LEN_W = 14;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN,
        FIN
    } burst_rd_state_t;

endpackage

// File: rtl/stream_fifo.sv
// Synchronous FIFO with registered occupancy count.
//   clk, rst_n : clock, synchronous active-low reset
//   push/wdata : write one entry (ignored when full)
//   pop/rdata  : rdata shows the head entry; pop removes it (ignored when empty)
//   count      : number of stored entries
//   full/empty : occupancy flags
// Push and pop in the same cycle leave count unchanged and keep order.
module stream_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 33,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] store [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = store[rd_ptr];

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_next(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_next(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: entries are only visible once counted.
    always_ff @(posedge clk) begin
        if (do_push) store[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/sram_burst_reader.sv
// Burst read master for one read-only port of the data SRAM.
//   clk, rst_n           : clock, synchronous active-low reset
//   cmd_valid/cmd_ready  : burst command handshake (accepted only when idle)
//   cmd_addr, cmd_len    : first word address, number of words (0..2^ADDR_W)
//   mem_en/mem_we        : SRAM enable / write enable (write enable tied low)
//   mem_addr, mem_dout   : SRAM address, read data (1-cycle latency)
//   m_valid/m_ready      : output stream handshake
//   m_data, m_last       : stream data, final-beat marker
//   done                 : one-cycle pulse when the burst has fully drained
module sram_burst_reader
    import tpu_mem_pkg::*;
#(
    parameter int ADDR_W     = tpu_mem_pkg::DATA_ADDR_W,
    parameter int DATA_W     = tpu_mem_pkg::DATA_W,
    parameter int LEN_W      = tpu_mem_pkg::BURST_LEN_W,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_dout,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last,
    output logic              done
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    burst_rd_state_t   state;
    logic [ADDR_W-1:0] addr;
    logic [LEN_W-1:0]  remaining;
    logic              inflight;
    logic              inflight_last;

    logic [CNT_W-1:0]  fifo_count;
    logic              fifo_full;
    logic              fifo_empty;
    logic [DATA_W:0]   fifo_rdata;
    logic [CNT_W:0]    credit_used;
    logic              issue;
    logic              final_read;
    logic              pop;

    // Credit is taken from registered state only, so m_ready never
    // reaches mem_en combinationally. A read in flight reserves a slot.
    assign credit_used = {1'b0, fifo_count} + {{CNT_W{1'b0}}, inflight};
    assign issue       = (state == READ) && !fifo_full &&
                         (credit_used < (CNT_W + 1)'(FIFO_DEPTH));
    assign final_read  = issue && (remaining == LEN_W'(1));
    assign pop         = m_valid && m_ready;

    assign cmd_ready = (state == IDLE);
    assign mem_en    = issue;
    assign mem_we    = 1'b0;
    assign mem_addr  = addr;
    assign done      = (state == FIN);
    assign m_valid   = !fifo_empty;
    assign m_data    = fifo_empty ? '0 : fifo_rdata[DATA_W-1:0];
    assign m_last    = !fifo_empty && fifo_rdata[DATA_W];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            addr          <= '0;
            remaining     <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
        end else begin
            inflight      <= issue;
            inflight_last <= final_read;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        addr      <= cmd_addr;
                        remaining <= cmd_len;
                        state     <= (cmd_len != '0) ? READ : FIN;
                    end
                end
                READ: begin
                    if (issue) begin
                        addr      <= addr + ADDR_W'(1);
                        remaining <= remaining - LEN_W'(1);
                        if (final_read) state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (fifo_empty && !inflight) state <= FIN;
                end
                FIN:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Returning read data lands in the FIFO the cycle after mem_en,
    // tagged with whether it was the burst's final read.
    stream_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_W + 1)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (inflight),
        .wdata ({inflight_last, mem_dout}),
        .pop   (pop),
        .rdata (fifo_rdata),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

endmodule

// File: tb/tb_sram_burst_reader.sv
module tb_sram_burst_reader;

    localparam int AW = 13;
    localparam int DW = 32;
    localparam int LW = 14;
    localparam int FD = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [AW-1:0] cmd_addr;
    logic [LW-1:0] cmd_len;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_dout;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
    logic          m_last;
    logic          done;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sram_burst_reader #(
        .ADDR_W     (AW),
        .DATA_W     (DW),
        .LEN_W      (LW),
        .FIFO_DEPTH (FD)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_addr  (cmd_addr),
        .cmd_len   (cmd_len),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_dout  (mem_dout),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .m_last    (m_last),
        .done      (done)
    );

    // SRAM model: 1-cycle read latency, read-only from this port.
    logic [DW-1:0] mem [8192];
    always @(posedge clk) if (mem_en === 1'b1) mem_dout <= mem[mem_addr];

    // Monitor: records reads and accepted beats with the edge index they occur on.
    logic [DW-1:0] beat_data [$];
    bit            beat_last [$];
    int            beat_cyc  [$];
    logic [AW-1:0] rd_addr   [$];
    int            rd_cyc    [$];
    int            outs = 0, max_outs = 0, stall_viol = 0;
    bit            prev_stall = 0;
    logic [DW-1:0] prev_data;
    logic          prev_last;

    always @(posedge clk) begin
        if (rst_n !== 1'b1) begin
            outs = 0;
            prev_stall = 0;
        end else begin
            if (prev_stall && (m_valid !== 1'b1 || m_data !== prev_data || m_last !== prev_last))
                stall_viol++;
            if (mem_en === 1'b1) begin
                rd_addr.push_back(mem_addr);
                rd_cyc.push_back(cyc + 1);
                outs++;
            end
            if (m_valid === 1'b1 && m_ready === 1'b1) begin
                beat_data.push_back(m_data);
                beat_last.push_back(m_last);
                beat_cyc.push_back(cyc + 1);
                outs--;
            end
            if (outs > max_outs) max_outs = outs;
            prev_stall = (m_valid === 1'b1) && (m_ready !== 1'b1);
            prev_data  = m_data;
            prev_last  = m_last;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        beat_data.delete(); beat_last.delete(); beat_cyc.delete();
        rd_addr.delete(); rd_cyc.delete();
        max_outs = 0; stall_viol = 0;
    endtask

    task automatic send_cmd(input logic [AW-1:0] a, input logic [LW-1:0] l,
                            output int hs, output bit ok);
        cmd_valid = 1'b1; cmd_addr = a; cmd_len = l;
        ok = 0; hs = -1;
        for (int i = 0; i < 200 && !ok; i++) begin
            if (cmd_ready === 1'b1) begin
                tick();
                hs = cyc;
                ok = 1;
            end else tick();
        end
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input int maxc, output int dc, output bit ok);
        ok = 0; dc = -1;
        for (int i = 0; i < maxc && !ok; i++) begin
            if (done === 1'b1) begin dc = cyc; ok = 1; end
            else tick();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; cmd_valid = 1'b0; m_ready = 1'b0;
        tick(); tick();
        checks += 8;
        if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready got %b exp 1", cmd_ready); end
        if (mem_en !== 1'b0)    begin errors++; $display("FAIL reset_mem_en got %b exp 0", mem_en); end
        if (mem_we !== 1'b0)    begin errors++; $display("FAIL reset_mem_we got %b exp 0", mem_we); end
        if (mem_addr !== '0)    begin errors++; $display("FAIL reset_mem_addr got %h exp 0", mem_addr); end
        if (m_valid !== 1'b0)   begin errors++; $display("FAIL reset_m_valid got %b exp 0", m_valid); end
        if (m_data !== '0)      begin errors++; $display("FAIL reset_m_data got %h exp 0", m_data); end
        if (m_last !== 1'b0)    begin errors++; $display("FAIL reset_m_last got %b exp 0", m_last); end
        if (done !== 1'b0)      begin errors++; $display("FAIL reset_done got %b exp 0", done); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        logic [DW-1:0] exp [4] = '{32'h0, 32'h3, 32'h6, 32'h9};
        int hs, dc; bit ok, okd;
        clear_mon(); m_ready = 1'b1;
        send_cmd(13'h010, 14'd4, hs, ok);
        wait_done(60, dc, okd);
        checks += 3;
        if (!ok)  begin errors++; $display("FAIL basic_handshake timed out"); end
        if (!okd) begin errors++; $display("FAIL basic_done timed out"); end
        if (dc !== hs + 7) begin errors++; $display("FAIL basic_done_cycle got %0d exp %0d", dc - hs, 7); end
        tick();
        checks += 4;
        if (done !== 1'b0)      begin errors++; $display("FAIL basic_done_width got %b exp 0", done); end
        if (cmd_ready !== 1'b1) begin errors++; $display("FAIL basic_ready_back got %b exp 1", cmd_ready); end
        if (rd_cyc.size() < 1 || rd_cyc[0] !== hs + 1) begin
            errors++; $display("FAIL basic_first_mem_en got %0d reads exp first at +1", rd_cyc.size());
        end
        if (beat_data.size() !== 4) begin errors++; $display("FAIL basic_beat_count got %0d exp 4", beat_data.size()); end
        for (int i = 0; i < 4 && i < beat_data.size(); i++) begin
            checks += 3;
            if (beat_data[i] !== exp[i]) begin errors++; $display("FAIL basic_data[%0d] got %h exp %h", i, beat_data[i], exp[i]); end
            if (beat_last[i] !== (i == 3)) begin errors++; $display("FAIL basic_last[%0d] got %b exp %b", i, beat_last[i], i == 3); end
            if (beat_cyc[i] !== hs + 3 + i) begin errors++; $display("FAIL basic_beat_cycle[%0d] got %0d exp %0d", i, beat_cyc[i] - hs, 3 + i); end
        end
    endtask

    task automatic test_wrap();
        logic [AW-1:0] ea [4] = '{13'h1FFE, 13'h1FFF, 13'h0000, 13'h0001};
        logic [DW-1:0] ed [4] = '{32'hA5001FFE, 32'hA5001FFF, 32'hA5000000, 32'hA5000001};
        int hs, dc; bit ok, okd;
        clear_mon(); m_ready = 1'b1;
        send_cmd(13'h1FFE, 14'd4, hs, ok);
        wait_done(60, dc, okd);
        tick();
        checks += 3;
        if (!ok || !okd) begin errors++; $display("FAIL wrap_complete got hs=%0b done=%0b exp 1 1", ok, okd); end
        if (rd_addr.size() !== 4)   begin errors++; $display("FAIL wrap_read_count got %0d exp 4", rd_addr.size()); end
        if (beat_data.size() !== 4) begin errors++; $display("FAIL wrap_beat_count got %0d exp 4", beat_data.size()); end
        for (int i = 0; i < 4 && i < rd_addr.size() && i < beat_data.size(); i++) begin
            checks += 3;
            if (rd_addr[i] !== ea[i])    begin errors++; $display("FAIL wrap_addr[%0d] got %h exp %h", i, rd_addr[i], ea[i]); end
            if (beat_data[i] !== ed[i])  begin errors++; $display("FAIL wrap_data[%0d] got %h exp %h", i, beat_data[i], ed[i]); end
            if (beat_last[i] !== (i == 3)) begin errors++; $display("FAIL wrap_last[%0d] got %b exp %b", i, beat_last[i], i == 3); end
        end
    endtask

    task automatic test_backpressure();
        int hs, dc; bit ok, okd;
        clear_mon(); m_ready = 1'b0;
        send_cmd(13'h010, 14'd16, hs, ok);
        for (int i = 0; i < 40 && cyc < hs + 12; i++) tick();
        checks += 2;
        if (rd_addr.size() !== FD)  begin errors++; $display("FAIL bp_stall_reads got %0d exp %0d", rd_addr.size(), FD); end
        if (beat_data.size() !== 0) begin errors++; $display("FAIL bp_stall_beats got %0d exp 0", beat_data.size()); end
        m_ready = 1'b1;
        wait_done(200, dc, okd);
        tick();
        checks += 5;
        if (!ok || !okd) begin errors++; $display("FAIL bp_complete got hs=%0b done=%0b exp 1 1", ok, okd); end
        if (max_outs > FD) begin errors++; $display("FAIL bp_outstanding got %0d exp <= %0d", max_outs, FD); end
        if (stall_viol !== 0) begin errors++; $display("FAIL bp_stable got %0d changes exp 0", stall_viol); end
        if (rd_addr.size() !== 16)   begin errors++; $display("FAIL bp_read_count got %0d exp 16", rd_addr.size()); end
        if (beat_data.size() !== 16) begin errors++; $display("FAIL bp_beat_count got %0d exp 16", beat_data.size()); end
        for (int i = 0; i < 16 && i < beat_data.size(); i++) begin
            checks += 2;
            if (beat_data[i] !== 32'(3 * i)) begin errors++; $display("FAIL bp_data[%0d] got %h exp %h", i, beat_data[i], 3 * i); end
            if (beat_last[i] !== (i == 15)) begin errors++; $display("FAIL bp_last[%0d] got %b exp %b", i, beat_last[i], i == 15); end
        end
    endtask

    task automatic test_len0();
        int hs; bit ok;
        clear_mon(); m_ready = 1'b1;
        send_cmd(13'h040, 14'd0, hs, ok);
        checks += 2;
        if (!ok) begin errors++; $display("FAIL len0_handshake timed out"); end
        if (done !== 1'b1) begin errors++; $display("FAIL len0_done got %b exp 1", done); end
        tick();
        checks += 2;
        if (done !== 1'b0)      begin errors++; $display("FAIL len0_done_width got %b exp 0", done); end
        if (cmd_ready !== 1'b1) begin errors++; $display("FAIL len0_ready got %b exp 1", cmd_ready); end
        tick(); tick(); tick();
        checks += 2;
        if (rd_addr.size() !== 0)   begin errors++; $display("FAIL len0_mem_en got %0d reads exp 0", rd_addr.size()); end
        if (beat_data.size() !== 0) begin errors++; $display("FAIL len0_beats got %0d exp 0", beat_data.size()); end
    endtask

    task automatic test_reset_mid();
        int hs, dc; bit ok, okd;
        clear_mon(); m_ready = 1'b1;
        send_cmd(13'h010, 14'd8, hs, ok);
        for (int i = 0; i < 4; i++) tick();
        checks += 1;
        if (beat_data.size() !== 2) begin errors++; $display("FAIL rmid_pre_beats got %0d exp 2", beat_data.size()); end
        rst_n = 1'b0;
        tick();
        checks += 6;
        if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rmid_cmd_ready got %b exp 1", cmd_ready); end
        if (mem_en !== 1'b0)    begin errors++; $display("FAIL rmid_mem_en got %b exp 0", mem_en); end
        if (mem_addr !== '0)    begin errors++; $display("FAIL rmid_mem_addr got %h exp 0", mem_addr); end
        if (m_valid !== 1'b0)   begin errors++; $display("FAIL rmid_m_valid got %b exp 0", m_valid); end
        if (m_data !== '0 || m_last !== 1'b0) begin errors++; $display("FAIL rmid_m_data got %h/%b exp 0/0", m_data, m_last); end
        if (done !== 1'b0)      begin errors++; $display("FAIL rmid_done got %b exp 0", done); end
        rst_n = 1'b1;
        clear_mon();
        for (int i = 0; i < 5; i++) tick();
        checks += 1;
        if (beat_data.size() !== 0 || rd_addr.size() !== 0) begin
            errors++; $display("FAIL rmid_stale got %0d beats %0d reads exp 0 0", beat_data.size(), rd_addr.size());
        end
        send_cmd(13'h020, 14'd2, hs, ok);
        wait_done(60, dc, okd);
        tick();
        checks += 2;
        if (!ok || !okd) begin errors++; $display("FAIL rmid_new_complete got hs=%0b done=%0b exp 1 1", ok, okd); end
        if (beat_data.size() !== 2) begin errors++; $display("FAIL rmid_new_count got %0d exp 2", beat_data.size()); end
        if (beat_data.size() == 2) begin
            checks += 2;
            if (beat_data[0] !== 32'hA5000020 || beat_last[0] !== 1'b0) begin
                errors++; $display("FAIL rmid_new_beat0 got %h/%b exp a5000020/0", beat_data[0], beat_last[0]);
            end
            if (beat_data[1] !== 32'hA5000021 || beat_last[1] !== 1'b1) begin
                errors++; $display("FAIL rmid_new_beat1 got %h/%b exp a5000021/1", beat_data[1], beat_last[1]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] ed [5] = '{32'h0, 32'h3, 32'h6, 32'hA5000030, 32'hA5000031};
        bit            el [5] = '{0, 0, 1, 0, 1};
        int hsa, hsb, da, ra, dc; bit ok, okd;
        clear_mon(); m_ready = 1'b1;
        send_cmd(13'h010, 14'd3, hsa, ok);
        cmd_valid = 1'b1; cmd_addr = 13'h030; cmd_len = 14'd2;
        da = -1; ra = -1;
        for (int i = 0; i < 60 && ra < 0; i++) begin
            if (done === 1'b1) da = cyc;
            if (cmd_ready === 1'b1) ra = cyc;
            else tick();
        end
        tick();
        hsb = cyc;
        cmd_valid = 1'b0;
        wait_done(60, dc, okd);
        tick(); tick();
        checks += 4;
        if (da !== hsa + 6) begin errors++; $display("FAIL b2b_done_a got %0d exp %0d", da - hsa, 6); end
        if (ra !== hsa + 7) begin errors++; $display("FAIL b2b_ready_idle got %0d exp %0d", ra - hsa, 7); end
        if (!ok || !okd) begin errors++; $display("FAIL b2b_complete got hs=%0b done=%0b exp 1 1", ok, okd); end
        if (beat_data.size() !== 5) begin errors++; $display("FAIL b2b_beat_count got %0d exp 5", beat_data.size()); end
        for (int i = 0; i < 5 && i < beat_data.size(); i++) begin
            checks += 2;
            if (beat_data[i] !== ed[i]) begin errors++; $display("FAIL b2b_data[%0d] got %h exp %h", i, beat_data[i], ed[i]); end
            if (beat_last[i] !== el[i]) begin errors++; $display("FAIL b2b_last[%0d] got %b exp %b", i, beat_last[i], el[i]); end
        end
        if (beat_cyc.size() == 5) begin
            checks += 1;
            if (beat_cyc[3] !== hsb + 3) begin errors++; $display("FAIL b2b_second_latency got %0d exp 3", beat_cyc[3] - hsb); end
        end
    endtask

    initial begin
        for (int a = 0; a < 8192; a++) mem[a] = 32'hA500_0000 | 32'(a);
        for (int i = 0; i < 16; i++) mem[16 + i] = 32'(3 * i);
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0; m_ready = 1'b0;
        test_reset();
        test_basic();
        test_wrap();
        test_backpressure();
        test_len0();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
